// File: rtl/golden_nonce_uart_tx.sv
// golden_nonce_uart_tx
//   Return path for mining results. Watches the golden_nonce register from the
//   hashing core and queues every new value in a small FIFO. Each queued value
//   is sent to the host as four 8N1 UART bytes, most significant byte first.
//
// Ports
//   clk           system clock, all logic on the rising edge
//   reset_n       asynchronous active-low reset
//   golden_nonce  golden-nonce register from the miner core
//   overflow_clr  synchronous pulse that clears the sticky overflow flag
//   uart_tx       serial line, idle high
//   tx_busy       high while a START, DATA or STOP bit is on the line
//   fifo_level    number of queued nonces not yet being sent
//   overflow      sticky: a new nonce was dropped because the FIFO was full
//   dbg_state     current transmitter state (IDLE/START/DATA/STOP encoding)
//
// Handshake: there is no backpressure toward the miner core. A nonce is taken
// in the cycle it differs from the previously seen value; internally the FIFO
// pops only when the transmitter is IDLE and the FIFO is non-empty.
module golden_nonce_uart_tx #(
    parameter int CLKS_PER_BIT    = 434,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [31:0]              golden_nonce,
    input  logic                     overflow_clr,
    output logic                     uart_tx,
    output logic                     tx_busy,
    output logic [FIFO_DEPTH_LOG2:0] fifo_level,
    output logic                     overflow,
    output logic [1:0]               dbg_state
);

    localparam int AW    = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0]   DEPTH_L   = (AW + 1)'(DEPTH);
    localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [31:0] last_nonce;
    logic [31:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    logic [1:0]  state;
    logic [31:0] shift;
    logic [1:0]  byte_idx;
    logic [2:0]  bit_idx;
    logic [15:0] baud;

    logic new_val;
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push;
    logic drop;
    logic baud_last;
    logic [7:0] cur_byte;

    // Pointers carry one extra wrap bit, so the difference is the fill level.
    assign fifo_level = wr_ptr - rd_ptr;
    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == DEPTH_L);

    assign new_val = (golden_nonce != last_nonce);
    assign pop     = (state == S_IDLE) && !fifo_empty;
    // A pop in the same cycle frees a slot, so a push on full still lands.
    assign push    = new_val && (!fifo_full || pop);
    assign drop    = new_val && fifo_full && !pop;

    assign baud_last = (baud == BAUD_LAST);
    assign cur_byte  = shift[31:24];
    assign tx_busy   = (state != S_IDLE);
    assign dbg_state = state;

    // The line is decoded straight from state registers so an async reset
    // forces it high in the same cycle, even mid-frame.
    always_comb begin
        uart_tx = 1'b1;
        case (state)
            S_START: uart_tx = 1'b0;
            S_DATA:  uart_tx = cur_byte[bit_idx];
            default: uart_tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= golden_nonce;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_nonce <= 32'h0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
        end else begin
            if (new_val) begin
                last_nonce <= golden_nonce;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            shift    <= 32'h0;
            byte_idx <= 2'd0;
            bit_idx  <= 3'd0;
            baud     <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shift    <= mem[rd_ptr[AW-1:0]];
                        byte_idx <= 2'd0;
                        baud     <= 16'd0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        baud    <= 16'd0;
                        bit_idx <= 3'd0;
                        state   <= S_DATA;
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud <= 16'd0;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                S_STOP: begin
                    if (baud_last) begin
                        baud <= 16'd0;
                        if (byte_idx != 2'd3) begin
                            // Next byte moves into the top lane; no idle gap.
                            byte_idx <= byte_idx + 2'd1;
                            shift    <= {shift[23:0], 8'h00};
                            state    <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// Testbench for golden_nonce_uart_tx (CLKS_PER_BIT=4, 4-entry FIFO).
// A frame-level model predicts the line, busy, level and overflow each cycle;
// a line decoder rebuilds bytes that are compared against literal words.
module tb_golden_nonce_uart_tx;

  localparam int CPB   = 4;
  localparam int DL2   = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 40 * CPB;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [31:0]    golden_nonce;
  logic           overflow_clr;
  logic           uart_tx;
  logic           tx_busy;
  logic [DL2:0]   fifo_level;
  logic           overflow;
  logic [1:0]     dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  golden_nonce_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(DL2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .golden_nonce (golden_nonce),
    .overflow_clr (overflow_clr),
    .uart_tx      (uart_tx),
    .tx_busy      (tx_busy),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] exp_q[$];
  logic [31:0] m_last   = 32'h0;
  logic [31:0] m_word   = 32'h0;
  logic        m_active = 1'b0;
  int          m_off    = 0;
  logic        m_ovf    = 1'b0;

  // Line level at offset o within a 4-byte frame (big-endian bytes, 8N1).
  function automatic logic exp_bit(logic [31:0] w, int o);
    int b;
    int slot;
    logic [7:0] bv;
    b    = o / (10 * CPB);
    slot = (o % (10 * CPB)) / CPB;
    bv   = 8'(w >> (8 * (3 - b)));
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return bv[slot-1];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    logic dropped;
    if (!reset_n) begin
      exp_q.delete();
      m_last   = 32'h0;
      m_active = 1'b0;
      m_off    = 0;
      m_ovf    = 1'b0;
    end else begin
      if (m_active) begin
        m_off++;
        if (m_off == FRAME) m_active = 1'b0;
      end else if (exp_q.size() != 0) begin
        m_word   = exp_q.pop_front();
        m_active = 1'b1;
        m_off    = 0;
      end
      dropped = 1'b0;
      if (golden_nonce != m_last) begin
        m_last = golden_nonce;
        if (exp_q.size() < DEPTH) exp_q.push_back(golden_nonce);
        else begin
          dropped = 1'b1;
          m_ovf   = 1'b1;
        end
      end
      if (overflow_clr && !dropped) m_ovf = 1'b0;
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    chk("uart_tx", 32'(uart_tx), 32'(m_active ? exp_bit(m_word, m_off) : 1'b1));
    chk("tx_busy", 32'(tx_busy), 32'(m_active));
    chk("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  end

  // ---------------- line decoder ----------------
  logic [7:0] rx_bytes[$];
  logic       rx_on   = 1'b0;
  logic       rx_prev = 1'b1;
  int         rx_cnt  = 0;
  logic [7:0] rx_sh   = 8'h0;

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_on   = 1'b0;
      rx_prev = 1'b1;
    end else begin
      if (!rx_on) begin
        if (rx_prev && !uart_tx) begin
          rx_on  = 1'b1;
          rx_cnt = 0;
        end
      end else begin
        rx_cnt++;
        for (int k = 0; k < 8; k++)
          if (rx_cnt == CPB * (1 + k) + CPB / 2) rx_sh[k] = uart_tx;
        if (rx_cnt == 9 * CPB + CPB / 2) begin
          chk("stop_bit", 32'(uart_tx), 32'h1);
          rx_bytes.push_back(rx_sh);
          rx_on = 1'b0;
        end
      end
      rx_prev = uart_tx;
    end
  end

  function automatic logic [31:0] rx_word(int i);
    if (rx_bytes.size() < 4 * i + 4) return 32'hxxxxxxxx;
    return {rx_bytes[4*i], rx_bytes[4*i+1], rx_bytes[4*i+2], rx_bytes[4*i+3]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(int n);
    repeat (n) next_cycle();
  endtask

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    do begin
      next_cycle();
      n++;
    end while ((tx_busy || fifo_level != 0) && n < budget);
    goto(2);
    chk("drain_busy", 32'(tx_busy), 32'h0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int peak;
    reset_n      = 1'b0;
    golden_nonce = 32'h0;
    overflow_clr = 1'b0;
    goto(3);
    chk("rst_uart_tx", 32'(uart_tx), 32'h1);
    chk("rst_busy", 32'(tx_busy), 32'h0);
    chk("rst_level", 32'(fifo_level), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    reset_n = 1'b1;
    goto(5);

    // Single nonce: change at c0, line low at c2, busy through c161.
    rx_bytes.delete();
    golden_nonce = 32'h0E33337A;
    next_cycle();
    chk("t1_level_c1", 32'(fifo_level), 32'h1);
    chk("t1_tx_c1", 32'(uart_tx), 32'h1);
    next_cycle();
    chk("t1_tx_c2", 32'(uart_tx), 32'h0);
    chk("t1_busy_c2", 32'(tx_busy), 32'h1);
    chk("t1_level_c2", 32'(fifo_level), 32'h0);
    goto(159);
    chk("t1_busy_c161", 32'(tx_busy), 32'h1);
    chk("t1_tx_c161", 32'(uart_tx), 32'h1);
    next_cycle();
    chk("t1_busy_c162", 32'(tx_busy), 32'h0);
    chk("t1_tx_c162", 32'(uart_tx), 32'h1);
    wait_idle(400);
    chk("t1_nbytes", 32'(rx_bytes.size()), 32'd4);
    chk("t1_word", rx_word(0), 32'h0E33337A);

    // Held value: one frame only.
    rx_bytes.delete();
    golden_nonce = 32'h12345678;
    peak = 0;
    for (int i = 0; i < 1000; i++) begin
      next_cycle();
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
    wait_idle(400);
    chk("t2_peak", 32'(peak), 32'd1);
    chk("t2_nbytes", 32'(rx_bytes.size()), 32'd4);
    chk("t2_word", rx_word(0), 32'h12345678);

    // Overflow: A at c0, B..F at c10..c14; F is dropped.
    rx_bytes.delete();
    golden_nonce = 32'h1;
    goto(10);
    for (int v = 2; v <= 6; v++) begin
      if (v == 6) chk("t3_level_c14", 32'(fifo_level), 32'd4);
      golden_nonce = 32'(v);
      next_cycle();
    end
    chk("t3_level_c15", 32'(fifo_level), 32'd4);
    chk("t3_ovf_c15", 32'(overflow), 32'h1);
    overflow_clr = 1'b1;
    next_cycle();
    overflow_clr = 1'b0;
    chk("t3_ovf_clr", 32'(overflow), 32'h0);
    wait_idle(2000);
    chk("t3_nbytes", 32'(rx_bytes.size()), 32'd20);
    for (int i = 0; i < 5; i++) chk("t3_word", rx_word(i), 32'(i + 1));

    // Push on full with simultaneous pop at the idle cycle c162.
    rx_bytes.delete();
    golden_nonce = 32'h7;
    goto(10);
    for (int v = 8; v <= 11; v++) begin
      golden_nonce = 32'(v);
      next_cycle();
    end
    chk("t4_level_c14", 32'(fifo_level), 32'd4);
    goto(148);
    chk("t4_tx_idle_c162", 32'(uart_tx), 32'h1);
    chk("t4_busy_c162", 32'(tx_busy), 32'h0);
    golden_nonce = 32'hC;
    next_cycle();
    chk("t4_level_c163", 32'(fifo_level), 32'd4);
    chk("t4_ovf_c163", 32'(overflow), 32'h0);
    chk("t4_tx_c163", 32'(uart_tx), 32'h0);
    wait_idle(2000);
    chk("t4_nbytes", 32'(rx_bytes.size()), 32'd24);
    for (int i = 0; i < 6; i++) chk("t4_word", rx_word(i), 32'(i + 7));

    // Reset in the middle of byte 1.
    golden_nonce = 32'h0E33337A;
    goto(20);
    golden_nonce = 32'hAAAA5555;
    goto(30);
    chk("t5_busy_pre", 32'(tx_busy), 32'h1);
    chk("t5_level_pre", 32'(fifo_level), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_tx", 32'(uart_tx), 32'h1);
    chk("t5_rst_busy", 32'(tx_busy), 32'h0);
    chk("t5_rst_level", 32'(fifo_level), 32'h0);
    golden_nonce = 32'h0E33337A;
    rx_bytes.delete();
    goto(2);
    reset_n = 1'b1;
    next_cycle();
    chk("t5_level_c1", 32'(fifo_level), 32'h1);
    next_cycle();
    chk("t5_tx_c2", 32'(uart_tx), 32'h0);
    wait_idle(400);
    chk("t5_nbytes", 32'(rx_bytes.size()), 32'd4);
    chk("t5_word", rx_word(0), 32'h0E33337A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
